// File: rtl/complex_mac_pkg.sv
// Shared types and helpers for the complex MAC tile: lane packing, the
// normal/conjugate product combine, and elaboration-time parameter checks.
package complex_mac_pkg;

    localparam int CMAC_MAX_DW = 31;

    typedef struct packed {
        logic signed [63:0] re;
        logic signed [63:0] im;
    } cmac_wide_t;

    typedef struct packed {
        logic vld;
        logic last;
        logic conj;
    } cmac_stage_t;

    // Bit offset of lane k in a bus of w-bit lanes.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

    // Accumulator width that can never wrap for the given geometry.
    function automatic int cmac_aw_nowrap(input int dw, input int max_acc);
        return 2 * dw + 1 + $clog2(max_acc);
    endfunction

    // Hard limits: the accumulator wraps by design, so AW only has to hold
    // one combined product; the combine runs in 64-bit arithmetic.
    function automatic bit cmac_params_ok(input int dw, input int aw, input int max_acc);
        return (max_acc >= 1) && (dw >= 2) && (dw <= CMAC_MAX_DW) && (aw >= 2 * dw + 1);
    endfunction

    function automatic cmac_wide_t cmac_combine(input logic conj,
                                                input logic signed [63:0] rr,
                                                input logic signed [63:0] ii,
                                                input logic signed [63:0] ri,
                                                input logic signed [63:0] ir);
        cmac_wide_t p;
        if (conj) begin
            p.re = rr + ii;
            p.im = ir - ri;
        end else begin
            p.re = rr - ii;
            p.im = ri + ir;
        end
        return p;
    endfunction

endpackage

// File: rtl/complex_mac_lane.sv
// One lane of the tile: registered products (S1), registered combine, then
// accumulate and single-entry output register (S2).
module complex_mac_lane
    import complex_mac_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 conj_i,
    input  logic                 acc_en_i,
    input  logic                 last_i,
    input  logic signed [DW-1:0] a_re_i,
    input  logic signed [DW-1:0] a_im_i,
    input  logic signed [DW-1:0] b_re_i,
    input  logic signed [DW-1:0] b_im_i,
    output logic signed [AW-1:0] out_re_o,
    output logic signed [AW-1:0] out_im_o
);

    localparam int MW = 2 * DW;
    localparam int PW = 2 * DW + 1;

    logic signed [MW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [MW-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [PW-1:0] p_re_d, p_im_d, p_re_q, p_im_q;
    logic signed [AW-1:0] sum_re, sum_im;
    logic signed [AW-1:0] acc_re_q, acc_im_q, out_re_q, out_im_q;
    cmac_wide_t           p_w;

    always_comb begin
        rr_d   = MW'(a_re_i) * MW'(b_re_i);
        ii_d   = MW'(a_im_i) * MW'(b_im_i);
        ri_d   = MW'(a_re_i) * MW'(b_im_i);
        ir_d   = MW'(a_im_i) * MW'(b_re_i);
        p_w    = cmac_combine(conj_i, 64'(rr_q), 64'(ii_q), 64'(ri_q), 64'(ir_q));
        p_re_d = PW'(p_w.re);
        p_im_d = PW'(p_w.im);
        sum_re = acc_re_q + AW'(p_re_q);
        sum_im = acc_im_q + AW'(p_im_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q     <= '0;
            ii_q     <= '0;
            ri_q     <= '0;
            ir_q     <= '0;
            p_re_q   <= '0;
            p_im_q   <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (en_i) begin
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
            if (acc_en_i) begin
                // A last beat flushes acc+p and restarts from zero, so the
                // next block follows without a bubble.
                if (last_i) begin
                    out_re_q <= sum_re;
                    out_im_q <= sum_im;
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                end else begin
                    acc_re_q <= sum_re;
                    acc_im_q <= sum_im;
                end
            end
        end
    end

    assign out_re_o = out_re_q;
    assign out_im_o = out_im_q;

endmodule

// File: rtl/complex_mac_tile.sv
// ROWS x COLS complex multiply-accumulate tile with per-block accumulation
// length, conjugate mode and valid/ready backpressure on the result.
module complex_mac_tile
    import complex_mac_pkg::*;
#(
    parameter int  ROWS        = 4,
    parameter int  COLS        = 4,
    parameter int  DW          = 16,
    parameter int  AW          = 40,
    parameter int  MAX_ACC_LEN = 256,
    localparam int CW          = $clog2(MAX_ACC_LEN + 1),
    localparam int NL          = ROWS * COLS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CW-1:0]      cfg_acc_len,
    input  logic               cfg_conj,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NL*DW-1:0]   in_img_re,
    input  logic [NL*DW-1:0]   in_img_im,
    input  logic [NL*DW-1:0]   in_ker_re,
    input  logic [NL*DW-1:0]   in_ker_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NL*AW-1:0]   out_re,
    output logic [NL*AW-1:0]   out_im,
    output logic               busy
);

    if (!cmac_params_ok(DW, AW, MAX_ACC_LEN)) begin : g_bad_params
        $error("complex_mac_tile: illegal DW/AW/MAX_ACC_LEN combination");
    end

    logic          en, beat, first, last_beat, conj_eff;
    logic [CW-1:0] len_eff;
    logic [CW-1:0] in_cnt_q, in_cnt_d, len_q, len_d;
    logic          conj_q, conj_d;
    cmac_stage_t   s1_q, s1_d;
    logic          s2_vld_q, s2_last_q;
    logic          out_valid_q, out_valid_d;

    // A held, unaccepted result freezes the whole pipeline.
    assign en       = !(out_valid_q && !out_ready);
    assign beat     = in_valid && en;
    assign in_ready = en;

    always_comb begin
        first    = (in_cnt_q == '0);
        len_eff  = len_q;
        conj_eff = conj_q;
        if (first) begin
            len_eff  = (cfg_acc_len == '0) ? CW'(1) : cfg_acc_len;
            conj_eff = cfg_conj;
        end
        last_beat = (in_cnt_q == len_eff - CW'(1));

        len_d    = len_q;
        conj_d   = conj_q;
        in_cnt_d = in_cnt_q;
        if (beat) begin
            len_d    = len_eff;
            conj_d   = conj_eff;
            in_cnt_d = last_beat ? '0 : in_cnt_q + CW'(1);
        end

        s1_d.vld  = beat;
        s1_d.last = beat && last_beat;
        s1_d.conj = conj_eff;

        // Handshake clears the entry unless a fresh result lands the same cycle.
        out_valid_d = out_valid_q;
        if (out_ready) out_valid_d = 1'b0;
        if (en && s2_vld_q && s2_last_q) out_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q    <= '0;
            len_q       <= CW'(1);
            conj_q      <= 1'b0;
            s1_q        <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (en) begin
                in_cnt_q  <= in_cnt_d;
                len_q     <= len_d;
                conj_q    <= conj_d;
                s1_q      <= s1_d;
                s2_vld_q  <= s1_q.vld;
                s2_last_q <= s1_q.last;
            end
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        complex_mac_lane #(
            .DW (DW),
            .AW (AW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en_i     (en),
            .conj_i   (s1_q.conj),
            .acc_en_i (s2_vld_q),
            .last_i   (s2_last_q),
            .a_re_i   (in_img_re[lane_lo(k, DW) +: DW]),
            .a_im_i   (in_img_im[lane_lo(k, DW) +: DW]),
            .b_re_i   (in_ker_re[lane_lo(k, DW) +: DW]),
            .b_im_i   (in_ker_im[lane_lo(k, DW) +: DW]),
            .out_re_o (out_re[lane_lo(k, AW) +: AW]),
            .out_im_o (out_im[lane_lo(k, AW) +: AW])
        );
    end

    assign out_valid = out_valid_q;
    assign busy      = (in_cnt_q != '0) || s1_q.vld || s2_vld_q || out_valid_q;

endmodule
